// File: rtl/id_stage_ctrl_pkg.sv
// Shared types for the decode-stage controller: control bundle, enums, trap FSM encoding.
package id_stage_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_CSR = 2'd3
  } wb_select_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    wb_select_t wb_select;
    logic       write_reg;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } control_t;

  localparam control_t CTRL_NONE = control_t'({$bits(control_t){1'b0}});

  // Legacy-compatible state encoding for the trap sequencer.
  typedef logic [1:0] trap_state_t;
  localparam trap_state_t ST_RUN        = 2'd0;
  localparam trap_state_t ST_TRAP_DRAIN = 2'd1;
  localparam trap_state_t ST_TRAP_WAIT  = 2'd2;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch, decoder, EX and trap handshakes of the decode stage bundled as one interface.
interface id_stage_ctrl_if;
  import id_stage_ctrl_pkg::*;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] dec_instr;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  control_t    dec_control;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  control_t    ex_control;
  logic        ex_redirect;
  logic        retire_valid;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        trap_ack;

  modport master (
    input  if_valid, if_pc, if_instr, dec_rs1, dec_rs2, dec_imm, dec_illegal, dec_control,
           ex_ready, ex_redirect, retire_valid, trap_ack,
    output if_ready, dec_instr, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_control,
           trap_req, trap_pc
  );

  modport slave (
    output if_valid, if_pc, if_instr, dec_rs1, dec_rs2, dec_imm, dec_illegal, dec_control,
           ex_ready, ex_redirect, retire_valid, trap_ack,
    input  if_ready, dec_instr, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_control,
           trap_req, trap_pc
  );

endinterface

// File: rtl/id_stage_ctrl_hazard_detect.sv
// Load-use compare: a load in ID/EX whose destination feeds the instruction now in ID.
module id_stage_ctrl_hazard_detect
  import id_stage_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  control_t   ex_control,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       haz
);

  // x0 is never a real producer, so a load into it cannot stall.
  always_comb begin
    haz = 1'b0;
    if (ex_valid && (ex_control.wb_select == WB_MEM) && ex_control.write_reg &&
        (ex_control.rd != 5'd0)) begin
      haz = (ex_control.rd == rs1) || (ex_control.rd == rs2);
    end else begin
      haz = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: IF/ID and ID/EX registers, load-use stall, redirect flush,
// in-flight tracking and the illegal-instruction drain/trap handshake.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic            clk,
  input  logic            reset,
  id_stage_ctrl_if.master bus
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] INFL_MAX  = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] INFL_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] INFL_ZERO = {CW{1'b0}};

  logic        id_valid_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_instr_r;
  logic        ex_valid_r;
  logic [31:0] ex_pc_r;
  logic [31:0] ex_imm_r;
  logic [4:0]  ex_rs1_r;
  logic [4:0]  ex_rs2_r;
  control_t    ex_control_r;
  logic        trap_req_r;
  logic [31:0] trap_pc_r;
  trap_state_t state_r;
  logic [CW-1:0] inflight_r;

  logic haz_s;
  logic adv_s;
  logic issue_s;
  logic fetch_s;

  id_stage_ctrl_hazard_detect u_hazard_detect (
    .ex_valid   (ex_valid_r),
    .ex_control (ex_control_r),
    .rs1        (bus.dec_rs1),
    .rs2        (bus.dec_rs2),
    .haz        (haz_s)
  );

  // Issue and fetch-accept decisions; a redirect makes the ID contents wrong-path.
  always_comb begin
    adv_s   = !ex_valid_r || bus.ex_ready;
    issue_s = id_valid_r && (state_r == ST_RUN) && !haz_s && !bus.dec_illegal && adv_s &&
              (inflight_r != INFL_MAX) && !bus.ex_redirect;
    fetch_s = (state_r == ST_RUN) && (!id_valid_r || issue_s) && !bus.ex_redirect;
  end

  assign bus.if_ready   = fetch_s;
  assign bus.dec_instr  = id_valid_r ? id_instr_r : NOP_INSTR;
  assign bus.ex_valid   = ex_valid_r;
  assign bus.ex_pc      = ex_pc_r;
  assign bus.ex_imm     = ex_imm_r;
  assign bus.ex_rs1     = ex_rs1_r;
  assign bus.ex_rs2     = ex_rs2_r;
  assign bus.ex_control = ex_control_r;
  assign bus.trap_req   = trap_req_r;
  assign bus.trap_pc    = trap_pc_r;

  // IF/ID slot: flushed by redirect, emptied by issue or by an acknowledged trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_r <= 1'b0;
      id_pc_r    <= 32'd0;
      id_instr_r <= NOP_INSTR;
    end else if (bus.ex_redirect) begin
      id_valid_r <= 1'b0;
    end else if (fetch_s && bus.if_valid) begin
      id_valid_r <= 1'b1;
      id_pc_r    <= bus.if_pc;
      id_instr_r <= bus.if_instr;
    end else if (issue_s || ((state_r == ST_TRAP_WAIT) && bus.trap_ack)) begin
      id_valid_r <= 1'b0;
    end
  end

  // ID/EX register: a redirect forces a bubble even when EX is not consuming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= 32'd0;
      ex_imm_r     <= 32'd0;
      ex_rs1_r     <= 5'd0;
      ex_rs2_r     <= 5'd0;
      ex_control_r <= CTRL_NONE;
    end else if (bus.ex_redirect || (adv_s && !issue_s)) begin
      ex_valid_r   <= 1'b0;
      ex_control_r <= CTRL_NONE;
    end else if (issue_s) begin
      ex_valid_r   <= 1'b1;
      ex_pc_r      <= id_pc_r;
      ex_imm_r     <= bus.dec_imm;
      ex_rs1_r     <= bus.dec_rs1;
      ex_rs2_r     <= bus.dec_rs2;
      ex_control_r <= bus.dec_control;
    end
  end

  // Issued-but-not-retired count, clamped at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_r <= INFL_ZERO;
    end else begin
      case ({issue_s, bus.retire_valid})
        2'b10: if (inflight_r != INFL_MAX) inflight_r <= inflight_r + INFL_ONE;
        2'b01: if (inflight_r != INFL_ZERO) inflight_r <= inflight_r - INFL_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Trap sequencer: freeze on an illegal op, drain the pipe, then hold the request until acked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RUN;
      trap_req_r <= 1'b0;
      trap_pc_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (id_valid_r && bus.dec_illegal && !bus.ex_redirect) begin
            state_r   <= ST_TRAP_DRAIN;
            trap_pc_r <= id_pc_r;
          end
        end
        ST_TRAP_DRAIN: begin
          if (bus.ex_redirect) begin
            state_r <= ST_RUN;
          end else if ((inflight_r == INFL_ZERO) && !ex_valid_r) begin
            state_r    <= ST_TRAP_WAIT;
            trap_req_r <= 1'b1;
          end
        end
        ST_TRAP_WAIT: begin
          if (bus.trap_ack) begin
            state_r    <= ST_RUN;
            trap_req_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          trap_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
